// File: rtl/div_sel_sequencer.sv
// Arbitrates two requesters for the clock-divider select and ramps sel_out one
// position at a time, stepping only after a low phase of div_clk has been seen.
module div_sel_sequencer #(
  parameter int SEL_W     = 5,
  parameter int MAX_SEL   = 24,
  parameter int RESET_SEL = 9,
  parameter int SETTLE    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [SEL_W-1:0] sel_a,
  input  logic             req_b,
  input  logic [SEL_W-1:0] sel_b,
  input  logic             div_clk,
  output logic [SEL_W-1:0] sel_out,
  output logic             busy,
  output logic             done_a,
  output logic             done_b
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_STEP,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t             state, state_next;
  logic               pend_a, pend_b;
  logic [SEL_W-1:0]   tgt_a, tgt_b, cur_tgt;
  logic               last_b;   // 1 = B was granted last
  logic               owner_b;  // requester of the operation in flight
  logic [CNT_W-1:0]   cnt;
  logic               grant_a, grant_b, step, at_tgt;

  function automatic logic [SEL_W-1:0] clamp(input logic [SEL_W-1:0] v);
    return (v > SEL_W'(MAX_SEL)) ? SEL_W'(MAX_SEL) : v;
  endfunction

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    step       = 1'b0;
    at_tgt     = (sel_out == cur_tgt);
    case (state)
      S_IDLE: begin
        if (pend_a && (!pend_b || last_b)) grant_a = 1'b1;
        else if (pend_b)                   grant_b = 1'b1;
        if (grant_a || grant_b) state_next = S_ALIGN;
      end
      S_ALIGN:  if (!div_clk) state_next = S_STEP;
      S_STEP: begin
        if (at_tgt) state_next = S_DONE;
        else begin
          step       = 1'b1;
          state_next = S_SETTLE;
        end
      end
      S_SETTLE: if (cnt == '0) state_next = S_ALIGN;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      sel_out <= SEL_W'(RESET_SEL);
      pend_a  <= 1'b0;
      pend_b  <= 1'b0;
      tgt_a   <= '0;
      tgt_b   <= '0;
      cur_tgt <= SEL_W'(RESET_SEL);
      last_b  <= 1'b1;
      owner_b <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done_a  <= 1'b0;
      done_b  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != S_IDLE);

      // A new request in the grant cycle re-arms the pending flag.
      pend_a <= req_a | (pend_a & ~grant_a);
      pend_b <= req_b | (pend_b & ~grant_b);
      if (req_a) tgt_a <= clamp(sel_a);
      if (req_b) tgt_b <= clamp(sel_b);

      if (grant_a) begin
        cur_tgt <= tgt_a;
        last_b  <= 1'b0;
        owner_b <= 1'b0;
      end else if (grant_b) begin
        cur_tgt <= tgt_b;
        last_b  <= 1'b1;
        owner_b <= 1'b1;
      end

      if (step) begin
        sel_out <= (sel_out < cur_tgt) ? sel_out + 1'b1 : sel_out - 1'b1;
        cnt     <= CNT_W'(SETTLE - 1);
      end else if (state == S_SETTLE && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end

      done_a <= (state == S_STEP) && at_tgt && !owner_b;
      done_b <= (state == S_STEP) && at_tgt &&  owner_b;
    end
  end

endmodule

// File: tb/tb_div_sel_sequencer.sv
// Scoreboard bench for div_sel_sequencer: expected done events are queued when
// requests are driven and compared against done pulses seen by a monitor.
module tb_div_sel_sequencer;

  localparam int SEL_W     = 5;
  localparam int MAX_SEL   = 24;
  localparam int RESET_SEL = 9;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_a = 1'b0, req_b = 1'b0;
  logic [SEL_W-1:0] sel_a = '0, sel_b = '0;
  logic             div_clk = 1'b0;
  logic [SEL_W-1:0] sel_out;
  logic             busy, done_a, done_b;

  div_sel_sequencer #(.SEL_W(SEL_W), .MAX_SEL(MAX_SEL), .RESET_SEL(RESET_SEL), .SETTLE(4)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .sel_a(sel_a),
    .req_b(req_b), .sel_b(sel_b),
    .div_clk(div_clk),
    .sel_out(sel_out), .busy(busy),
    .done_a(done_a), .done_b(done_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             is_b;
    logic [SEL_W-1:0] sel;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  n_changes = 0;

  // div_clk generator: 4 clk high / 4 clk low when running, held low otherwise.
  bit dclk_run = 1'b0;
  int dcnt = 0;
  always @(negedge clk) begin
    #2;
    if (dclk_run) begin
      dcnt++;
      if (dcnt == 4) begin
        dcnt    = 0;
        div_clk = ~div_clk;
      end
    end else begin
      div_clk = 1'b0;
    end
  end

  // Monitor: ramp properties on every sel_out change, and done-pulse capture.
  logic [SEL_W-1:0] prev_sel = '0;
  logic             dclk_prev = 1'b0;
  bit               have_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (have_prev && sel_out != prev_sel) begin
        n_changes++;
        n_checks++;
        if (!((sel_out == prev_sel + 1'b1) || (sel_out == prev_sel - 1'b1)))
          $display("FAIL step_size: sel_out %0d -> %0d, required change of 1", prev_sel, sel_out);
        else n_pass++;
        // The step is taken the cycle after ALIGN saw div_clk low.
        n_checks++;
        if (dclk_prev !== 1'b0)
          $display("FAIL step_align: div_clk before step was %b, required 0", dclk_prev);
        else n_pass++;
        n_checks++;
        if (sel_out > SEL_W'(MAX_SEL))
          $display("FAIL max_sel: sel_out %0d, required <= %0d", sel_out, MAX_SEL);
        else n_pass++;
      end
      if (done_a || done_b) begin
        n_checks++;
        if (done_a && done_b) $display("FAIL done_excl: done_a=1 done_b=1, required not both");
        else n_pass++;
        obs_q.push_back('{is_b: done_b, sel: sel_out});
      end
    end
    prev_sel  = sel_out;
    have_prev = !rst;
    dclk_prev = div_clk;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [SEL_W-1:0] model_clamp(input int v);
    return (v > MAX_SEL) ? SEL_W'(MAX_SEL) : SEL_W'(v);
  endfunction

  task automatic expect_done(input logic is_b, input int v);
    exp_q.push_back('{is_b: is_b, sel: model_clamp(v)});
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic issue(input logic do_a, input int va, input logic do_b, input int vb);
    req_a = do_a;
    sel_a = SEL_W'(va);
    req_b = do_b;
    sel_b = SEL_W'(vb);
    tick();
    req_a = 1'b0;
    req_b = 1'b0;
    sel_a = '1;
    sel_b = '1;
  endtask

  task automatic wait_done(input string name, input int budget);
    int  waited = 0;
    ev_t o, e;
    while (obs_q.size() == 0 && waited < budget) begin
      tick();
      waited++;
    end
    n_checks++;
    if (obs_q.size() == 0) begin
      $display("FAIL %s: no done pulse within %0d cycles", name, budget);
    end else if (exp_q.size() == 0) begin
      o = obs_q.pop_front();
      $display("FAIL %s: unexpected done is_b=%0d sel=%0d, required none", name, o.is_b, o.sel);
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      if (o !== e)
        $display("FAIL %s: done is_b=%0d sel=%0d, required is_b=%0d sel=%0d",
                 name, o.is_b, o.sel, e.is_b, e.sel);
      else n_pass++;
    end
  endtask

  task automatic wait_sel(input string name, input logic [SEL_W-1:0] v, input int budget);
    int waited = 0;
    while (sel_out !== v && waited < budget) begin
      tick();
      waited++;
    end
    n_checks++;
    if (sel_out !== v) $display("FAIL %s: sel_out %0d, required to reach %0d", name, sel_out, v);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    n_checks += 4;
    if (sel_out !== SEL_W'(RESET_SEL)) $display("FAIL reset_sel: got %0d required %0d", sel_out, RESET_SEL);
    else n_pass++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else n_pass++;
    if (done_a !== 1'b0) $display("FAIL reset_done_a: got %b required 0", done_a); else n_pass++;
    if (done_b !== 1'b0) $display("FAIL reset_done_b: got %b required 0", done_b); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_ramp();
    int base;
    do_reset();
    dclk_run = 1'b1;
    base = n_changes;
    expect_done(1'b0, 12);
    issue(1'b1, 12, 1'b0, 0);
    wait_done("ramp_done", 400);
    n_checks += 2;
    if (sel_out !== 5'd12) $display("FAIL ramp_final: got %0d required 12", sel_out); else n_pass++;
    if (n_changes - base !== 3) $display("FAIL ramp_changes: got %0d required 3", n_changes - base);
    else n_pass++;
    repeat (10) tick();
    n_checks++;
    if (obs_q.size() != 0) $display("FAIL ramp_extra_done: got %0d extra required 0", obs_q.size());
    else n_pass++;
  endtask

  task automatic test_min_latency();
    bit exp_busy[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    bit exp_done[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    dclk_run = 1'b0;
    repeat (2) tick();
    expect_done(1'b1, 9);
    issue(1'b0, 0, 1'b1, 9);
    for (int k = 0; k < 5; k++) begin
      n_checks += 3;
      if (busy !== exp_busy[k]) $display("FAIL lat_busy N+%0d: got %b required %b", k + 1, busy, exp_busy[k]);
      else n_pass++;
      if (done_b !== exp_done[k]) $display("FAIL lat_done_b N+%0d: got %b required %b", k + 1, done_b, exp_done[k]);
      else n_pass++;
      if (sel_out !== 5'd9) $display("FAIL lat_sel N+%0d: got %0d required 9", k + 1, sel_out);
      else n_pass++;
      tick();
    end
    wait_done("lat_done", 5);
  endtask

  task automatic test_arbitration();
    do_reset();
    dclk_run = 1'b1;
    expect_done(1'b0, 5);
    expect_done(1'b1, 15);
    issue(1'b1, 5, 1'b1, 15);
    wait_done("arb_first", 400);
    wait_done("arb_second", 600);
    n_checks++;
    if (sel_out !== 5'd15) $display("FAIL arb_final: got %0d required 15", sel_out); else n_pass++;
  endtask

  task automatic test_clamp();
    expect_done(1'b0, 31);
    issue(1'b1, 31, 1'b0, 0);
    wait_done("clamp_done", 600);
    repeat (20) tick();
    n_checks++;
    if (sel_out !== SEL_W'(MAX_SEL)) $display("FAIL clamp_final: got %0d required %0d", sel_out, MAX_SEL);
    else n_pass++;
  endtask

  task automatic test_retarget();
    do_reset();
    dclk_run = 1'b1;
    expect_done(1'b0, 14);
    issue(1'b1, 14, 1'b0, 0);
    wait_sel("retarget_at11", 5'd11, 300);
    expect_done(1'b0, 7);
    issue(1'b1, 7, 1'b0, 0);
    wait_done("retarget_first", 400);
    wait_done("retarget_second", 600);
    n_checks++;
    if (sel_out !== 5'd7) $display("FAIL retarget_final: got %0d required 7", sel_out); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    dclk_run = 1'b0;
    repeat (2) tick();
    // Second req_a lands in the grant cycle of the first: it must stay pending.
    expect_done(1'b0, 10);
    expect_done(1'b0, 6);
    issue(1'b1, 10, 1'b0, 0);
    issue(1'b1, 6, 1'b0, 0);
    wait_done("b2b_first", 200);
    wait_done("b2b_second", 300);
    // Both pending while A runs: last grant was A, so B goes next.
    expect_done(1'b0, 10);
    issue(1'b1, 10, 1'b0, 0);
    tick();
    expect_done(1'b1, 8);
    expect_done(1'b0, 11);
    issue(1'b1, 11, 1'b1, 8);
    wait_done("rr_first", 200);
    wait_done("rr_second", 200);
    wait_done("rr_third", 200);
  endtask

  task automatic test_reset_mid();
    do_reset();
    dclk_run = 1'b1;
    expect_done(1'b0, 20);
    issue(1'b1, 20, 1'b0, 0);
    wait_sel("mid_at13", 5'd13, 300);
    rst = 1'b1;
    tick();
    n_checks += 4;
    if (sel_out !== SEL_W'(RESET_SEL)) $display("FAIL mid_sel: got %0d required %0d", sel_out, RESET_SEL);
    else n_pass++;
    if (busy !== 1'b0) $display("FAIL mid_busy: got %b required 0", busy); else n_pass++;
    if (done_a !== 1'b0) $display("FAIL mid_done_a: got %b required 0", done_a); else n_pass++;
    if (done_b !== 1'b0) $display("FAIL mid_done_b: got %b required 0", done_b); else n_pass++;
    rst = 1'b0;
    exp_q.delete();
    repeat (30) tick();
    n_checks++;
    if (obs_q.size() != 0) $display("FAIL mid_no_done: got %0d done pulses required 0", obs_q.size());
    else n_pass++;
    expect_done(1'b1, 11);
    issue(1'b0, 0, 1'b1, 11);
    wait_done("mid_after", 300);
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_min_latency();
    test_arbitration();
    test_clamp();
    test_retarget();
    test_back_to_back();
    test_reset_mid();
    repeat (5) tick();
    n_checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0)
      $display("FAIL scoreboard_drain: expected left %0d observed left %0d, required 0/0",
               exp_q.size(), obs_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
